// File: rtl/m_shift_register_n.sv
// Parameterised shift register with a fixed-length run sequencer.
// A run applies the selected shift operation for exactly STEPS cycles,
// then pulses done for one cycle before returning to idle.
module m_shift_register_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEPS = 32,
  parameter int unsigned CW    = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [1:0]       serial_in,
  input  logic             invert,
  output logic [WIDTH-1:0] data_out,
  output logic             is_zero,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    step_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] shift_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;

  // Extended vectors let the fill bits enter at the bottom; truncation drops the MSBs.
  logic [WIDTH:0]   ext1;
  logic [WIDTH+1:0] ext2;

  // Next value of the data register for the currently selected mode.
  always_comb begin
    ext1    = {data_q, serial_in[0]};
    ext2    = {data_q, serial_in};
    shift_d = data_q;
    unique case (mode)
      2'b00: shift_d = data_q;
      2'b01: shift_d = ext1[WIDTH-1:0];
      2'b10: shift_d = ext2[WIDTH-1:0];
      2'b11: shift_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      default: shift_d = data_q;
    endcase
  end

  // Run sequencer with registered busy/done; clr overrides everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load) begin
            data_q <= data_in;
          end
          if (start) begin
            state_q <= StRun;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          data_q <= shift_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(STEPS - 1)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output view: inversion is cosmetic, zero detect looks at the raw register.
  always_comb begin
    data_out   = invert ? ~data_q : data_q;
    is_zero    = (data_q == '0);
    busy       = busy_q;
    done       = done_q;
    step_count = cnt_q;
  end

endmodule

// File: tb/tb_m_shift_register_n.sv
// Randomised and directed bench for m_shift_register_n (WIDTH=8, STEPS=4).
module tb_m_shift_register_n;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned STEPS = 4;
  localparam int unsigned CW    = 3;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             load = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [1:0]       serial_in = 2'b00;
  logic             invert = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             is_zero;
  logic             busy;
  logic             done;
  logic [CW-1:0]    step_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: value, cycles left in the run, pending done, shift count.
  int m_q    = 0;
  int m_left = 0;
  int m_done = 0;
  int m_cnt  = 0;

  m_shift_register_n #(
    .WIDTH(WIDTH),
    .STEPS(STEPS),
    .CW   (CW)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .data_in   (data_in),
    .load      (load),
    .start     (start),
    .mode      (mode),
    .serial_in (serial_in),
    .invert    (invert),
    .data_out  (data_out),
    .is_zero   (is_zero),
    .busy      (busy),
    .done      (done),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  wire [13:0] obs = {data_out, is_zero, busy, done, step_count};

  function automatic int shifted(int q, logic [1:0] md, logic [1:0] si);
    case (md)
      2'b01:   return (q * 2 + int'(si[0])) % 256;
      2'b10:   return (q * 4 + int'(si)) % 256;
      2'b11:   return (q / 2) + (q >= 128 ? 128 : 0);
      default: return q;
    endcase
  endfunction

  function automatic logic [13:0] expect_vec();
    logic [7:0] qv;
    logic [7:0] cv;
    qv = 8'(m_q);
    cv = 8'(m_cnt);
    return {(invert ? ~qv : qv), (m_q == 0), (m_left > 0), (m_done != 0), cv[2:0]};
  endfunction

  // Advance model with the inputs as they stand, then clock the DUT.
  task automatic cycle();
    if (clr) begin
      m_q = 0; m_cnt = 0; m_left = 0; m_done = 0;
    end else if (m_left > 0) begin
      m_q    = shifted(m_q, mode, serial_in);
      m_cnt  = m_cnt + 1;
      m_left = m_left - 1;
      m_done = (m_left == 0) ? 1 : 0;
    end else if (m_done != 0) begin
      m_done = 0;
    end else begin
      if (load) m_q = int'(data_in);
      if (start) begin
        m_left = STEPS;
        m_cnt  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; load = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; load = 1'b1; start = 1'b1; data_in = 8'hA5;
    cycle();
    n_tests++;
    if (obs !== expect_vec() || data_out !== 8'h00 || is_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: got %h want %h", obs, expect_vec());
    end
    invert = 1'b1;
    #1;
    n_tests++;
    if (data_out !== 8'hFF || is_zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_invert: got %h want ff/1/0/0", {data_out, is_zero, busy, done});
    end
    invert = 1'b0;
    idle_inputs();
    cycle();
  endtask

  // Loads a value, starts, then checks each run edge against a fixed sequence.
  task automatic run_directed(string name, logic [7:0] init, logic [1:0] md, logic [1:0] si,
                              logic [31:0] seq);
    int busy_n;
    int done_n;
    logic [31:0] s;
    s = seq;
    busy_n = 0; done_n = 0;
    mode = md; serial_in = si;
    load = 1'b1; data_in = init;
    cycle();
    load = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    if (busy) busy_n++;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (busy) busy_n++;
      if (done) done_n++;
      n_tests++;
      if (data_out !== s[31-8*i -: 8] || obs !== expect_vec()) begin
        n_fail++;
        $display("FAIL %s_step%0d: got %h want %h (vec %h want %h)", name, i,
                 data_out, s[31-8*i -: 8], obs, expect_vec());
      end
    end
    n_tests++;
    if (step_count !== 3'd4 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_final: got count %0d done %b want 4 1", name, step_count, done);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (busy) busy_n++;
      if (done) done_n++;
    end
    n_tests++;
    if (busy_n != 4 || done_n != 1) begin
      n_fail++;
      $display("FAIL %s_pulses: got busy %0d done %0d want 4 1", name, busy_n, done_n);
    end
  endtask

  task automatic test_left_shift();
    run_directed("left1", 8'h81, 2'b01, 2'b00, 32'h02040810);
  endtask

  task automatic test_arith_right();
    run_directed("asr", 8'h80, 2'b11, 2'b00, 32'hC0E0F0F8);
  endtask

  task automatic test_shift_two();
    load = 1'b1; data_in = 8'h01; mode = 2'b10; serial_in = 2'b11;
    cycle();
    load = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    invert = 1'b1;
    #1;
    n_tests++;
    if (data_out !== 8'h00 || is_zero !== 1'b0 || obs !== expect_vec()) begin
      n_fail++;
      $display("FAIL shift2_invert: got %h/%b want 00/0", data_out, is_zero);
    end
    invert = 1'b0;
    #1;
    n_tests++;
    if (data_out !== 8'hFF) begin
      n_fail++;
      $display("FAIL shift2_result: got %h want ff", data_out);
    end
    cycle();
  endtask

  task automatic test_abort();
    int done_n;
    done_n = 0;
    load = 1'b1; start = 1'b1; data_in = 8'h3C; mode = 2'b01; serial_in = 2'b01;
    cycle();
    idle_inputs();
    cycle();
    cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    n_tests++;
    if (data_out !== 8'h00 || is_zero !== 1'b1 || busy !== 1'b0 || step_count !== 3'd0
        || obs !== expect_vec()) begin
      n_fail++;
      $display("FAIL abort: got %h want 00 zero idle cnt0", obs);
    end
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (done) done_n++;
    end
    n_tests++;
    if (done_n != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d pulses want 0", done_n);
    end
  endtask

  task automatic test_ignored();
    int busy_n;
    busy_n = 0;
    load = 1'b1; data_in = 8'h0F; mode = 2'b01; serial_in = 2'b00;
    cycle();
    load = 1'b0; start = 1'b1;
    cycle();
    if (busy) busy_n++;
    load = 1'b1; data_in = 8'h55;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (busy) busy_n++;
    end
    load = 1'b0;
    n_tests++;
    if (data_out !== 8'hF0 || done !== 1'b1 || obs !== expect_vec()) begin
      n_fail++;
      $display("FAIL ignored_run: got %h done %b want f0 1", data_out, done);
    end
    cycle();
    start = 1'b0;
    if (busy) busy_n++;
    n_tests++;
    if (busy_n != 4 || busy !== 1'b0 || data_out !== 8'hF0) begin
      n_fail++;
      $display("FAIL ignored_noqueue: got busy %0d/%b q %h want 4/0 f0", busy_n, busy, data_out);
    end
    load = 1'b1; start = 1'b1; data_in = 8'hA5;
    cycle();
    idle_inputs();
    n_tests++;
    if (data_out !== 8'hA5 || busy !== 1'b1 || step_count !== 3'd0) begin
      n_fail++;
      $display("FAIL load_start: got %h busy %b cnt %0d want a5 1 0", data_out, busy, step_count);
    end
    for (int i = 0; i < 6; i++) cycle();
  endtask

  task automatic test_zero();
    load = 1'b1; data_in = 8'h00; invert = 1'b1;
    cycle();
    load = 1'b0;
    n_tests++;
    if (data_out !== 8'hFF || is_zero !== 1'b1 || obs !== expect_vec()) begin
      n_fail++;
      $display("FAIL zero_detect: got %h/%b want ff/1", data_out, is_zero);
    end
    invert = 1'b0;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      clr       = ($urandom_range(0, 29) == 0);
      load      = ($urandom_range(0, 2) == 0);
      start     = ($urandom_range(0, 3) == 0);
      data_in   = 8'($urandom);
      mode      = 2'($urandom);
      serial_in = 2'($urandom);
      invert    = 1'($urandom);
      cycle();
      n_tests++;
      if (obs !== expect_vec()) begin
        n_fail++;
        errs++;
        if (errs <= 10) $display("FAIL random_cycle%0d: got %h want %h", i, obs, expect_vec());
      end
    end
    idle_inputs();
    invert = 1'b0;
  endtask

  initial begin
    test_reset();
    test_left_shift();
    test_arith_right();
    test_shift_two();
    test_abort();
    test_ignored();
    test_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m_shift_register_n.md
M_SHIFT_REGISTER_N -- requirements
Module: m_shift_register_n

Interface
REQ-001 Parameter WIDTH, default 32: data register width in bits, minimum 2.
REQ-002 Parameter STEPS, default 32: shift cycles per run, minimum 1.
REQ-003 Parameter CW, default 6: step counter width, at least ceil(log2(STEPS+1)).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 clr  in  1  synchronous active-high reset.
REQ-007 data_in  in  WIDTH  parallel load value.
REQ-008 load  in  1  capture data_in, honoured only in IDLE.
REQ-009 start  in  1  begin a run, honoured only in IDLE.
REQ-010 mode  in  2  shift operation: 00 hold, 01 shift left 1, 10 shift left 2, 11 arithmetic shift right 1.
REQ-011 serial_in  in  2  fill bits for the vacated LSBs in modes 01 and 10.
REQ-012 invert  in  1  combinational output inversion.
REQ-013 data_out  out  WIDTH  register contents, optionally inverted.
REQ-014 is_zero  out  1  register contents equal zero.
REQ-015 busy  out  1  high while the run is in progress.
REQ-016 done  out  1  one-cycle run-complete pulse.
REQ-017 step_count  out  CW  shifts performed in the current or last run.

Function
REQ-018 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-019 In IDLE with load=1, q SHALL take data_in at the next edge.
REQ-020 In IDLE with start=1, the state SHALL go to RUN and step_count SHALL go to 0 at the next edge.
REQ-021 In IDLE with load=1 and start=1 together, q SHALL take data_in and the state SHALL enter RUN at the same edge; the first shift applies on the following edge.
REQ-022 In RUN, each edge SHALL apply the mode function to q and increment step_count.
REQ-023 In RUN, mode and serial_in SHALL be sampled every cycle; a mode change mid-run takes effect at the next edge.
REQ-024 Mode 01: q <= {q[WIDTH-2:0], serial_in[0]}.
REQ-025 Mode 10: q <= {q[WIDTH-3:0], serial_in[1:0]}; the two MSBs are discarded.
REQ-026 Mode 11: q <= {q[WIDTH-1], q[WIDTH-1:1]}; serial_in is ignored.
REQ-027 Mode 00: q SHALL hold, while step_count still increments.
REQ-028 On the edge where step_count==STEPS-1 in RUN, the final shift SHALL apply, step_count SHALL become STEPS, and the state SHALL go to DONE.
REQ-029 RUN SHALL therefore last exactly STEPS cycles; STEPS=1 gives a single RUN cycle.
REQ-030 load and start SHALL be ignored in RUN and DONE, with no queuing.
REQ-031 DONE SHALL last exactly one cycle with done=1 and q held, then return to IDLE.
REQ-032 busy SHALL be 1 exactly when the state is RUN; done SHALL be 1 exactly when the state is DONE.
REQ-033 data_out SHALL equal invert ? ~q : q, combinationally; invert does not change q.
REQ-034 is_zero SHALL equal (q == 0), computed on the un-inverted q and independent of invert.
REQ-035 step_count SHALL hold its final value in DONE and IDLE until the next start.

Reset
REQ-036 clr=1 at an edge SHALL force q=0, step_count=0 and state IDLE in any state.
REQ-037 After reset: data_out=0 (all ones if invert=1), is_zero=1, busy=0, done=0.
REQ-038 clr SHALL take priority over load, start and any in-progress run.
REQ-039 A run aborted by clr SHALL produce no done pulse.

Verification (WIDTH=8, STEPS=4)
REQ-040 Left shift: load 0x81, start, mode 01, serial_in 00 -> q sequence 0x02, 0x04, 0x08, 0x10; busy high for 4 cycles; done pulses once; step_count=4.
REQ-041 Arithmetic right shift: load 0x80, mode 11 -> q sequence 0xC0, 0xE0, 0xF0, 0xF8; final data_out=0xF8.
REQ-042 Shift by two: load 0x01, mode 10, serial_in 11 -> q sequence 0x07, 0x1F, 0x7F, 0xFF; with invert=1, data_out=0x00 and is_zero=0.
REQ-043 Abort: clr asserted after 2 RUN cycles -> next cycle q=0, is_zero=1, busy=0, step_count=0, and no done pulse ever.
REQ-044 Ignored requests: load 0x55 with start during RUN, and start during DONE -> run result unaffected, no extra RUN cycles; then load and start together in IDLE -> q=data_in and busy=1 at the same edge.
REQ-045 Zero detect: load 0x00, invert=1 -> data_out=0xFF and is_zero=1.
